// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: 2-flop sync, per-channel stability filter, press/release strobes.
// Auto-repeat for held buttons is compiled in when DEBOUNCE_REPEAT_EN is defined.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | level 0, synchronised input agrees, counter at 0
// CHK_PRESS   | level 0, input reads 1, counting toward a press
// HELD        | level 1, synchronised input agrees, counter at 0
// CHK_RELEASE | level 1, input reads 0, counting toward a release
module debounce_bank #(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int ACTIVE_LOW_IN = 0,
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] button_level,
   output logic [CHANNELS-1:0] button_pressed,
   output logic [CHANNELS-1:0] button_released,
   output logic [CHANNELS-1:0] button_repeat,
   output logic                any_pressed
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
`ifdef DEBOUNCE_REPEAT_EN
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);
`endif

   // Level is state[1], so the debounced output comes straight from the state register.
   typedef enum logic [1:0] {
      S_IDLE        = 2'b00,
      S_CHK_PRESS   = 2'b01,
      S_HELD        = 2'b10,
      S_CHK_RELEASE = 2'b11
   } state_t;

   logic [CHANNELS-1:0] w_raw;
   logic [CHANNELS-1:0] r_sync1;
   logic [CHANNELS-1:0] r_sync2;

   assign w_raw = (ACTIVE_LOW_IN != 0) ? ~button : button;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t        r_state;
      state_t        w_state_nxt;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;
      logic          w_in;
      logic          w_done;
      logic          w_press_nxt;
      logic          w_release_nxt;
      logic          r_pressed;
      logic          r_released;

      assign w_in   = r_sync2[g];
      assign w_done = (r_cnt == CW'(STABLE_CYCLES - 1));

      always_comb begin
         w_state_nxt   = r_state;
         w_cnt_nxt     = '0;
         w_press_nxt   = 1'b0;
         w_release_nxt = 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_in) begin
                  w_state_nxt = S_CHK_PRESS;
                  w_cnt_nxt   = CW'(1);
               end
            end
            S_CHK_PRESS: begin
               if (!w_in) begin
                  w_state_nxt = S_IDLE;
               end else if (w_done) begin
                  w_state_nxt = S_HELD;
                  w_press_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_HELD: begin
               if (!w_in) begin
                  w_state_nxt = S_CHK_RELEASE;
                  w_cnt_nxt   = CW'(1);
               end
            end
            S_CHK_RELEASE: begin
               if (w_in) begin
                  w_state_nxt = S_HELD;
               end else if (w_done) begin
                  w_state_nxt   = S_IDLE;
                  w_release_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
         end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pressed  <= w_press_nxt;
            r_released <= w_release_nxt;
         end
      end

      assign button_level[g]    = r_state[1];
      assign button_pressed[g]  = r_pressed;
      assign button_released[g] = r_released;

`ifdef DEBOUNCE_REPEAT_EN
      logic [HW-1:0] r_hcnt;
      logic          r_first_done;
      logic          r_rep;
      logic [HW-1:0] w_target_m1;

      assign w_target_m1 = r_first_done ? HW'(REPEAT_CYCLES - 1) : HW'(HOLD_CYCLES - 1);

      // A repeat that would coincide with the release strobe is dropped.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hcnt       <= '0;
            r_first_done <= 1'b0;
            r_rep        <= 1'b0;
         end else if (!r_state[1] || w_release_nxt) begin
            r_hcnt       <= '0;
            r_first_done <= 1'b0;
            r_rep        <= 1'b0;
         end else if (r_hcnt == w_target_m1) begin
            r_hcnt       <= '0;
            r_first_done <= 1'b1;
            r_rep        <= 1'b1;
         end else begin
            r_hcnt <= r_hcnt + HW'(1);
            r_rep  <= 1'b0;
         end
      end

      assign button_repeat[g] = r_rep;
`else
      assign button_repeat[g] = 1'b0;
`endif
   end

   assign any_pressed = |button_level;

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner for the board's button inputs. For each raw asynchronous button input it:
- synchronises the input to `clk`,
- filters contact bounce with a per-channel stability counter,
- outputs a clean level plus single-cycle press and release strobes.

It sits between the top-level pins and the game/control FSMs. It replaces single-channel, level-only debouncing. An optional auto-repeat generator for held buttons is compiled in by macro.

## Interface
- `CHANNELS`, default 4: number of independent button channels (≥1).
- `STABLE_CYCLES`, default 1_000_000: consecutive cycles of a changed synchronised input required before the debounced level follows (≥2).
- `ACTIVE_LOW_IN`, default 0: when 1, each raw input is inverted before synchronisation, so a pressed button is logical 1 internally.
- `HOLD_CYCLES`, default 25_000_000: cycles after a press before the first repeat strobe (`DEBOUNCE_REPEAT_EN` only, ≥1).
- `REPEAT_CYCLES`, default 5_000_000: cycles between subsequent repeat strobes (`DEBOUNCE_REPEAT_EN` only, ≥1).

Ports:
- `clk`  in  1: system clock. The single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `button`  in  `CHANNELS`: raw asynchronous button inputs.
- `button_level`  out  `CHANNELS`: debounced level, 1 = pressed.
- `button_pressed`  out  `CHANNELS`: one-cycle strobe on a debounced 0→1 transition.
- `button_released`  out  `CHANNELS`: one-cycle strobe on a debounced 1→0 transition.
- `button_repeat`  out  `CHANNELS`: one-cycle auto-repeat strobe while held. Constant 0 without the macro.
- `any_pressed`  out  1: OR of `button_level`.

## Operation
- Polarity: raw input is XORed with `ACTIVE_LOW_IN`, then passed through a 2-flop synchroniser per channel. Synchroniser flops reset to 0, the released value.
- Per-channel filter: a counter of width `$clog2(STABLE_CYCLES+1)`.
  - Each edge where the synchronised input ≠ `button_level`: the counter increments.
  - Each edge where they are equal: the counter clears to 0.
  - When an increment would reach `STABLE_CYCLES`:
    - `button_level` toggles and the counter clears;
    - `button_pressed` (new level 1) or `button_released` (new level 0) asserts for exactly that one cycle.
- Channel state machine, two-bit encoding:
  - IDLE (level 0, count 0) → CHK_PRESS on input 1.
  - CHK_PRESS → IDLE on input 0 (bounce rejected); → HELD on count reaching `STABLE_CYCLES`.
  - HELD → CHK_RELEASE on input 0.
  - CHK_RELEASE → HELD on input 1; → IDLE on count reaching `STABLE_CYCLES`.
- Any bounce shorter than `STABLE_CYCLES` cycles produces no output activity.
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle.
- `any_pressed` is combinational from the `button_level` registers.

## Timing
- All outputs are registered except `any_pressed`.
- Reset value of all outputs is 0. Counters and state reset to 0 / IDLE.
- Latency: the raw change is first sampled at edge k, and `button_level` plus the strobe update at edge k+1+`STABLE_CYCLES`, provided the input is held constant.
- `rst_n` asserted mid-count or while HELD:
  - all channels return immediately to IDLE with outputs 0;
  - no `button_released` strobe is emitted.
- After reset deassertion, a button already held emits `button_pressed` after the normal latency.
- Strobes never overlap on one channel. `button_pressed` and `button_released` are mutually exclusive per cycle.

## Configuration
- Macro: `DEBOUNCE_REPEAT_EN`.
- Defined:
  - each channel has a hold counter of `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)` bits, cleared on `button_pressed` and while the level is 0.
  - In HELD or CHK_RELEASE, the counter counts every cycle. `button_repeat` pulses for one cycle when it reaches `HOLD_CYCLES` after the press edge, then every `REPEAT_CYCLES` thereafter. The counter reloads 0 on each repeat.
  - Repeat stops in the same cycle `button_released` asserts.
- Undefined: no hold counters are synthesised, and `button_repeat` is tied to 0.

## Test plan
Bench parameters: `CHANNELS`=2, `STABLE_CYCLES`=4, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=3, `ACTIVE_LOW_IN`=0.
- **Clean press:** ch0 raw 0→1 before edge 0, held → `button_level[0]`=1 and `button_pressed[0]`=1 at edge 5 only. Ch1 stays 0.
- **Bounce rejection:** ch0 raw toggles 1,0,1,0 with 2-cycle periods, then 0 → no strobes, `button_level[0]` stays 0. A further bounce 1 for 3 cycles then 0 → still no strobe.
- **Release:** from HELD, ch0 raw → 0 before edge 20 → `button_released[0]`=1 at edge 25, level 0. A 3-cycle glitch back to 1 during CHK_RELEASE restarts the count.
- **Simultaneous channels:** both raw → 1 on the same edge → both `button_pressed` bits at the same edge, `any_pressed`=1. Then release ch1 only → only `button_released[1]`.
- **Reset mid-operation:** `rst_n`=0 while ch0 HELD and ch1 in CHK_PRESS → all outputs 0 immediately, no release strobe. Deassert with ch0 still 1 → press strobe 5 edges later.
- **Repeat (macro on):** hold ch0 → `button_repeat[0]` at 10, 13, 16 cycles after the press strobe. Release → strobes stop, with none in the release cycle. With the macro off → `button_repeat` is constantly 0.
